// File: rtl/em_ttl_pkg.sv
// Shared definitions for the emulated TTL counter family: run/halt state,
// direction encoding and the WIDTH/MODULUS legality check.
package em_ttl_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // A modulus is usable when it lies in 2..2^width and the width is 1..32.
    function automatic bit modulus_legal(input int width, input longint unsigned modulus);
        bit ok;
        ok = 1'b0;
        if (width >= 1 && width <= 32) begin
            ok = (modulus >= 64'd2) && (modulus <= (64'd1 << width));
        end
        return ok;
    endfunction

endpackage

// File: rtl/em_mod_step.sv
// Combinational modulo step: next count value and wrap flag for one count
// step in the given direction. Comparisons are done one bit wider than the
// count so that MODULUS == 2^WIDTH needs no special case.
module em_mod_step
    import em_ttl_pkg::*;
#(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MODULUS = 16
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up,
    output logic [WIDTH-1:0] next,
    output logic             wrap
);

    localparam logic [WIDTH:0] MOD_EXT  = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] LAST_EXT = MOD_EXT - (WIDTH+1)'(1);

    logic [WIDTH:0] w_cnt_ext;
    logic           w_term_up;
    logic           w_term_dn;

    assign w_cnt_ext = {1'b0, count};
    // Out-of-range values are terminal in both directions.
    assign w_term_up = (w_cnt_ext >= LAST_EXT);
    assign w_term_dn = (w_cnt_ext == '0) || (w_cnt_ext >= MOD_EXT);

    // Select the stepped value; terminal values wrap to the opposite end.
    always_comb begin
        next = '0;
        wrap = 1'b0;
        if (up == DIR_UP) begin
            if (w_term_up) begin
                next = '0;
                wrap = 1'b1;
            end else begin
                next = count + WIDTH'(1);
            end
        end else begin
            if (w_term_dn) begin
                next = LAST_EXT[WIDTH-1:0];
                wrap = 1'b1;
            end else begin
                next = count - WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/em_counter_pn.sv
// Programmable up/down modulo counter with 74161-style cascade carry,
// one-shot halt mode and a registered terminal-count pulse.
module em_counter_pn
    import em_ttl_pkg::*;
#(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MODULUS = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             nload,
    input  logic             ent,
    input  logic             enp,
    input  logic             up,
    input  logic             oneshot,
    input  logic [WIDTH-1:0] parallel_in,
    output logic [WIDTH-1:0] count,
    output logic             rco,
    output logic             tc_pulse,
    output logic             done
);

    generate
        if (!modulus_legal(WIDTH, MODULUS)) begin : g_bad_params
            $error("em_counter_pn: MODULUS must be 2..2^WIDTH and WIDTH 1..32");
        end
    endgenerate

    state_e           r_state;
    logic [WIDTH-1:0] r_count;
    logic             r_tc;

    logic [WIDTH-1:0] w_next;
    logic             w_wrap;
    logic             w_step;

    em_mod_step #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_step (
        .count (r_count),
        .up    (up),
        .next  (w_next),
        .wrap  (w_wrap)
    );

    assign w_step = ent & enp & (r_state == ST_RUN);

    // Count/state/pulse update with priority clr > load > count step.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_count <= '0;
            r_state <= ST_RUN;
            r_tc    <= 1'b0;
        end else if (!nload) begin
            r_count <= parallel_in;
            r_state <= ST_RUN;
            r_tc    <= 1'b0;
        end else if (w_step) begin
            r_count <= w_next;
            r_tc    <= w_wrap;
            if (w_wrap && oneshot) begin
                r_state <= ST_HALT;
            end
        end else begin
            r_tc <= 1'b0;
        end
    end

    // The wrap flag of the step unit doubles as the terminal-value detect.
    assign rco      = ent & w_wrap;
    assign count    = r_count;
    assign tc_pulse = r_tc;
    assign done     = (r_state == ST_HALT);

endmodule

// File: tb/tb_em_counter_pn.sv
// Bench for em_counter_pn: directed vector table, up/down sequences,
// randomized run against a reference model, and a two-stage cascade.
module tb_em_counter_pn;

    localparam int M = 10;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance, WIDTH=4, MODULUS=10
    logic       clr, nload, ent, enp, up, oneshot;
    logic [3:0] pin;
    logic [3:0] count;
    logic       rco, tc_pulse, done;

    em_counter_pn #(.WIDTH(4), .MODULUS(10)) dut (
        .clk         (clk),
        .clr         (clr),
        .nload       (nload),
        .ent         (ent),
        .enp         (enp),
        .up          (up),
        .oneshot     (oneshot),
        .parallel_in (pin),
        .count       (count),
        .rco         (rco),
        .tc_pulse    (tc_pulse),
        .done        (done)
    );

    // Cascade pair, WIDTH=4, MODULUS=16
    logic       c_clr, c_nload, c_ent, c_enp, c_up, c_os;
    logic [3:0] c_pin;
    logic [3:0] lo_count, hi_count;
    logic       lo_rco, hi_rco, lo_tc, hi_tc, lo_done, hi_done;

    em_counter_pn #(.WIDTH(4), .MODULUS(16)) u_lo (
        .clk (clk), .clr (c_clr), .nload (c_nload), .ent (c_ent), .enp (c_enp),
        .up (c_up), .oneshot (c_os), .parallel_in (c_pin),
        .count (lo_count), .rco (lo_rco), .tc_pulse (lo_tc), .done (lo_done)
    );

    em_counter_pn #(.WIDTH(4), .MODULUS(16)) u_hi (
        .clk (clk), .clr (c_clr), .nload (c_nload), .ent (lo_rco), .enp (c_enp),
        .up (c_up), .oneshot (c_os), .parallel_in (c_pin),
        .count (hi_count), .rco (hi_rco), .tc_pulse (hi_tc), .done (hi_done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       clr, nload, ent, enp, up, os;
        logic [3:0] pin;
        logic [3:0] e_count;
        logic       e_tc, e_done, e_rco;
    } vec_t;

    function automatic vec_t mk(input int c, input int nl, input int et, input int ep,
                                input int u, input int o, input int p,
                                input int ec, input int etc, input int ed, input int er);
        vec_t v;
        v.clr = c[0]; v.nload = nl[0]; v.ent = et[0]; v.enp = ep[0];
        v.up = u[0]; v.os = o[0]; v.pin = p[3:0];
        v.e_count = ec[3:0]; v.e_tc = etc[0]; v.e_done = ed[0]; v.e_rco = er[0];
        return v;
    endfunction

    vec_t vt[24];

    // Reference model state (plain integers)
    int  m_cnt;
    bit  m_halt;
    bit  m_tc;

    function automatic bit m_terminal(input int c, input bit u);
        if (u) return (c >= M - 1);
        return (c == 0) || (c >= M);
    endfunction

    task automatic model_edge(input bit i_clr, input bit i_nl, input bit i_ent, input bit i_enp,
                              input bit i_up, input bit i_os, input int i_pin);
        if (i_clr) begin
            m_cnt = 0; m_halt = 0; m_tc = 0;
        end else if (!i_nl) begin
            m_cnt = i_pin; m_halt = 0; m_tc = 0;
        end else if (i_ent && i_enp && !m_halt) begin
            m_tc = m_terminal(m_cnt, i_up);
            if (i_up) m_cnt = m_tc ? 0 : m_cnt + 1;
            else      m_cnt = m_tc ? M - 1 : m_cnt - 1;
            if (m_tc && i_os) m_halt = 1;
        end else begin
            m_tc = 0;
        end
    endtask

    initial begin
        clr = 1'b1; nload = 1'b1; ent = 1'b1; enp = 1'b1; up = 1'b1; oneshot = 1'b0; pin = '0;
        c_clr = 1'b1; c_nload = 1'b1; c_ent = 1'b1; c_enp = 1'b0; c_up = 1'b1; c_os = 1'b0; c_pin = '0;

        //          clr nl ent enp up os pin | cnt tc done rco
        vt[0]  = mk(1, 1, 1, 1, 1, 0, 0,   0, 0, 0, 0);
        vt[1]  = mk(1, 1, 1, 1, 0, 0, 0,   0, 0, 0, 1);
        vt[2]  = mk(1, 0, 1, 1, 1, 0, 5,   0, 0, 0, 0);
        vt[3]  = mk(0, 0, 1, 1, 1, 1, 7,   7, 0, 0, 0);
        vt[4]  = mk(0, 1, 1, 1, 1, 1, 0,   8, 0, 0, 0);
        vt[5]  = mk(0, 1, 1, 1, 1, 1, 0,   9, 0, 0, 1);
        vt[6]  = mk(0, 1, 1, 1, 1, 1, 0,   0, 1, 1, 0);
        vt[7]  = mk(0, 1, 1, 1, 1, 1, 0,   0, 0, 1, 0);
        vt[8]  = mk(0, 1, 1, 1, 1, 0, 0,   0, 0, 1, 0);
        vt[9]  = mk(0, 0, 1, 1, 1, 0, 3,   3, 0, 0, 0);
        vt[10] = mk(0, 0, 0, 1, 1, 0, 9,   9, 0, 0, 0);
        vt[11] = mk(0, 1, 0, 1, 1, 0, 0,   9, 0, 0, 0);
        vt[12] = mk(0, 1, 1, 0, 1, 0, 0,   9, 0, 0, 1);
        vt[13] = mk(0, 0, 1, 1, 1, 0, 2,   2, 0, 0, 0);
        vt[14] = mk(0, 0, 1, 1, 1, 0, 12, 12, 0, 0, 1);
        vt[15] = mk(0, 1, 1, 1, 1, 0, 0,   0, 1, 0, 0);
        vt[16] = mk(0, 0, 1, 1, 0, 0, 12, 12, 0, 0, 1);
        vt[17] = mk(0, 1, 1, 1, 0, 0, 0,   9, 1, 0, 0);
        vt[18] = mk(0, 1, 1, 1, 0, 0, 0,   8, 0, 0, 0);
        vt[19] = mk(0, 0, 1, 1, 1, 1, 9,   9, 0, 0, 1);
        vt[20] = mk(0, 1, 1, 1, 1, 1, 0,   0, 1, 1, 0);
        vt[21] = mk(1, 1, 1, 1, 1, 1, 0,   0, 0, 0, 0);
        vt[22] = mk(0, 1, 1, 1, 0, 1, 0,   9, 1, 1, 0);
        vt[23] = mk(0, 1, 1, 1, 0, 0, 0,   9, 0, 1, 0);

        for (int i = 0; i < 24; i++) begin
            clr = vt[i].clr; nload = vt[i].nload; ent = vt[i].ent; enp = vt[i].enp;
            up = vt[i].up; oneshot = vt[i].os; pin = vt[i].pin;
            step();
            check($sformatf("vec%0d count", i), 64'(count),    64'(vt[i].e_count));
            check($sformatf("vec%0d tc", i),    64'(tc_pulse), 64'(vt[i].e_tc));
            check($sformatf("vec%0d done", i),  64'(done),     64'(vt[i].e_done));
            check($sformatf("vec%0d rco", i),   64'(rco),      64'(vt[i].e_rco));
        end

        // Up sequence from reset: 0..9, 0
        clr = 1'b1; nload = 1'b1; ent = 1'b1; enp = 1'b1; up = 1'b1; oneshot = 1'b0;
        step();
        clr = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            check($sformatf("up%0d count", i), 64'(count),    64'(i % 10));
            check($sformatf("up%0d rco", i),   64'(rco),      64'((i % 10) == 9));
            check($sformatf("up%0d tc", i),    64'(tc_pulse), 64'(i == 10));
            step();
        end

        // Down sequence from reset: 0, 9, 8, ..., 0
        clr = 1'b1; up = 1'b0;
        step();
        clr = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            check($sformatf("dn%0d count", i), 64'(count),    64'((10 - i) % 10));
            check($sformatf("dn%0d rco", i),   64'(rco),      64'(((10 - i) % 10) == 0));
            check($sformatf("dn%0d tc", i),    64'(tc_pulse), 64'(i == 1));
            step();
        end

        // Randomized run against the reference model
        clr = 1'b1;
        model_edge(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0);
        step();
        for (int i = 0; i < 400; i++) begin
            clr     = ($urandom_range(0, 39) == 0);
            nload   = ($urandom_range(0, 9) != 0);
            ent     = ($urandom_range(0, 5) != 0);
            enp     = ($urandom_range(0, 5) != 0);
            up      = $urandom_range(0, 1) == 1;
            oneshot = ($urandom_range(0, 7) == 0);
            pin     = 4'($urandom_range(0, 15));
            model_edge(clr, nload, ent, enp, up, oneshot, int'(pin));
            step();
            check($sformatf("rnd%0d count", i), 64'(count),    64'(m_cnt));
            check($sformatf("rnd%0d tc", i),    64'(tc_pulse), 64'(m_tc));
            check($sformatf("rnd%0d done", i),  64'(done),     64'(m_halt));
            check($sformatf("rnd%0d rco", i),   64'(rco),      64'(ent && m_terminal(m_cnt, up)));
        end

        // Two-stage cascade: 256 steps through 8 bits
        c_clr = 1'b1; c_enp = 1'b0;
        step();
        c_clr = 1'b0; c_enp = 1'b1;
        for (int i = 0; i < 255; i++) step();
        check("casc 255 value", 64'({hi_count, lo_count}), 64'(8'hFF));
        check("casc 255 hi_rco", 64'(hi_rco), 64'(1));
        check("casc 255 lo_rco", 64'(lo_rco), 64'(1));
        step();
        check("casc 256 value", 64'({hi_count, lo_count}), 64'(8'h00));
        check("casc 256 hi_rco", 64'(hi_rco), 64'(0));
        check("casc 256 lo_tc", 64'(lo_tc), 64'(1));
        check("casc 256 hi_tc", 64'(hi_tc), 64'(1));
        check("casc 256 done", 64'({hi_done, lo_done}), 64'(0));
        step();
        check("casc 257 value", 64'({hi_count, lo_count}), 64'(8'h01));
        check("casc 257 hi_tc", 64'(hi_tc), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/em_counter_pn.md
# em_counter_pn

Parametrised synchronous up/down counter. It is the successor to the 4-bit 74161-style emulation, generalised to any width and modulus. It adds direction control, a one-shot (count-to-terminal-and-halt) mode, a registered terminal-count pulse, and a halt flag. It is used in the emulated TTL layer wherever a cascadable programmable divider or event counter is needed.

## Interface
Parameters:
- WIDTH, 4: counter width in bits, 1..32.
- MODULUS, 16: count sequence length; legal range 2..2^WIDTH.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- clr  input  1  reset, synchronous, active-high.
- nload  input  1  synchronous parallel load, active-low.
- ent  input  1  count enable T; also gates rco.
- enp  input  1  count enable P.
- up  input  1  direction: 1 counts up, 0 counts down.
- oneshot  input  1  1 halts the counter after the next wrap.
- parallel_in  input  WIDTH  load value.
- count  output  WIDTH  current count.
- rco  output  1  combinational ripple carry/borrow for cascading.
- tc_pulse  output  1  registered one-cycle pulse after a wrap.
- done  output  1  high while halted in one-shot mode.

## Operation
- Two states: RUN and HALT. Reset state is RUN.
- Priority at each edge: clr, then nload==0, then counting.
- On clr==1:
  - count=0, state=RUN, tc_pulse=0, done=0.
- On nload==0 (and clr==0):
  - count=parallel_in, state=RUN, tc_pulse=0.
  - A load value ≥ MODULUS is accepted unchanged (see out-of-range rules).
- A count step occurs when clr==0, nload==1, ent==1, enp==1 and state==RUN.
- Step rules, up==1:
  - If count ≥ MODULUS-1, next count=0 and the step is a wrap.
  - Otherwise count+1.
- Step rules, up==0:
  - If count==0 or count ≥ MODULUS, next count=MODULUS-1 and the step is a wrap.
  - Otherwise count-1.
- Arithmetic is done in WIDTH+1 bits and never overflows. MODULUS==2^WIDTH behaves as a plain binary counter.
- Terminal value: MODULUS-1 when up==1, 0 when up==0. Out-of-range values (≥ MODULUS) count as terminal in both directions.
- rco = ent AND terminal(count, up). It does not depend on enp, state or oneshot.
- tc_pulse: set to 1 at the edge following a wrap step. Cleared at every other edge.
- One-shot behaviour:
  - A wrap step with oneshot==1 moves the state RUN→HALT.
  - In HALT, count holds and done=1.
  - HALT exits only on clr or nload==0.
  - oneshot changing while in HALT has no effect.
  - With oneshot==0, wraps never change state.
- Enables low (ent or enp) in RUN: count and state hold; tc_pulse clears at the next edge.

## Timing
- Reset values of all outputs:
  - count=0, tc_pulse=0, done=0.
  - rco=0 with up==0 and ent==1 gives rco=1 (count=0 is terminal). rco is combinational.
- Count latency: one edge from enables/nload to a new count.
- rco changes in the same cycle as count, ent or up. Cascade by wiring rco to the next stage's ent with a shared enp.
- tc_pulse is high for exactly one cycle, the cycle after the wrap edge. It is also high if that next edge has clr, since clr clears it only at the following edge.
- done rises in the cycle after the wrap edge and falls in the cycle after the exiting clr/load edge.
- Simultaneous events:
  - clr with nload==0: clr wins.
  - nload==0 with the enables high: load wins and no wrap occurs.
  - up toggling on the same edge as a step: the sampled value of up is used.
- Reset mid-operation (including in HALT): count=0 and RUN on the next edge; no tc_pulse.

## Structure
- Shared package em_ttl_pkg holds:
  - the state enum (ST_RUN, ST_HALT);
  - direction constants DIR_UP=1, DIR_DOWN=0;
  - a legality check function for MODULUS versus WIDTH, used by an elaboration-time assertion.
- Sub-module em_mod_step: combinational next-value and wrap-flag calculation.
  - Ports: count, up, next, wrap.
  - Reused by the planned em_counter_pn variants.
- The top level holds the state register, count register, tc_pulse/done registers and the rco logic.

## Test plan
- WIDTH=4, MODULUS=10, up=1, ent=enp=1 from reset:
  - count 0..9 then 0.
  - rco=1 only while count==9.
  - tc_pulse=1 in the cycle where count shows 0 after the wrap.
- WIDTH=4, MODULUS=10, up=0 from reset: 0 → 9 → 8 … → 0. rco=1 at count 0.
- One-shot, MODULUS=10, load 7, oneshot=1, up=1: 8, 9, 0, then held at 0 with done=1.
  - Further enables have no effect.
  - nload=0 with parallel_in=3 gives count=3 and done=0.
- Out-of-range load of 12 with MODULUS=10:
  - up=1: next count 0 and tc_pulse.
  - up=0: next count 9.
  - rco=1 while count==12 with ent=1.
- Priority check:
  - clr=1 with nload=0, parallel_in=5 → count=0.
  - nload=0 at count 9 with the enables high → count=parallel_in, no tc_pulse.
  - ent=0 at count 9: rco=0 and count holds.
- Cascade of two instances (WIDTH=4, MODULUS=16, low-stage rco to high-stage ent): after 255 steps, {hi,lo}=8'hFF; step 256 gives 8'h00, with hi.rco=1 in the preceding cycle.
